// File: rtl/bcd_entry_reader_pkg.sv
// Shared constants for the BCD entry reader.
//   state_t  : controller states IDLE / CONV / DONE / ERR
//   BCD_MAX  : largest legal decimal digit code
//   NDIG     : number of digits held and converted
package bcd_entry_reader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam int BCD_MAX = 9;
    localparam int NDIG    = 3;

endpackage

// File: rtl/bcd_entry_reader_decoder.sv
// BCD digit to 7-segment pattern, active-high segments.
//   digit : 4-bit BCD code
//   seg   : [0:6] = segments a..g; codes above 9 blank the display
module decoder (
    input  logic [3:0] digit,
    output logic [0:6] seg
);

    always_comb begin
        seg = 7'b0000000;
        case (digit)
            4'd0: seg = 7'b1111110;
            4'd1: seg = 7'b0110000;
            4'd2: seg = 7'b1101101;
            4'd3: seg = 7'b1111001;
            4'd4: seg = 7'b0110011;
            4'd5: seg = 7'b1011011;
            4'd6: seg = 7'b1011111;
            4'd7: seg = 7'b1110000;
            4'd8: seg = 7'b1111111;
            4'd9: seg = 7'b1111011;
            default: seg = 7'b0000000;
        endcase
    end

endmodule

// File: rtl/bcd_entry_reader.sv
// Keyed decimal entry: shifts in up to three BCD digits, converts them to
// binary on request with a shift-and-add x10 accumulator, echoes digits on
// three 7-segment outputs.
//   clk, rst_s_n           : clock, synchronous active-low reset
//   digit_in, digit_strobe : digit to load and its one-cycle load pulse
//   enter, clear           : start conversion / discard entry and error
//   value, valid, busy, err: result, result-updated pulse, converting, bad digit seen
//   unidades/decenas/centenas : echoes of d0 / d1 / d2
module bcd_entry_reader
    import bcd_entry_reader_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_s_n,
    input  logic [3:0]       digit_in,
    input  logic             digit_strobe,
    input  logic             enter,
    input  logic             clear,
    output logic [WIDTH-1:0] value,
    output logic             valid,
    output logic             busy,
    output logic             err,
    output logic [0:6]       unidades,
    output logic [0:6]       decenas,
    output logic [0:6]       centenas
);

    state_t           state_q, state_d;
    logic [1:0]       step_q, step_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [3:0]       d0_q, d0_d, d1_q, d1_d, d2_q, d2_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic             valid_q, valid_d;

    logic [3:0]       cur_digit;
    logic [WIDTH-1:0] acc_step;
    logic             digit_bad;

    // Step index selects the digit, most significant first.
    always_comb begin
        case (step_q)
            2'd0:    cur_digit = d2_q;
            2'd1:    cur_digit = d1_q;
            default: cur_digit = d0_q;
        endcase
    end

    // acc*10 as acc*8 + acc*2 keeps the datapath to adders only.
    assign acc_step  = (acc_q << 3) + (acc_q << 1) + WIDTH'(cur_digit);
    assign digit_bad = (digit_in > 4'(BCD_MAX));

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        d0_d    = d0_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        acc_d   = acc_q;
        value_d = value_q;
        valid_d = 1'b0;

        if (clear) begin
            state_d = IDLE;
            step_d  = 2'd0;
            cnt_d   = 2'd0;
            d0_d    = 4'd0;
            d1_d    = 4'd0;
            d2_d    = 4'd0;
            acc_d   = '0;
            value_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enter) begin
                        state_d = CONV;
                        step_d  = 2'd0;
                        acc_d   = '0;
                    end else if (digit_strobe) begin
                        if (digit_bad) begin
                            state_d = ERR;
                        end else begin
                            d2_d  = d1_q;
                            d1_d  = d0_q;
                            d0_d  = digit_in;
                            cnt_d = (cnt_q == 2'(NDIG)) ? cnt_q : cnt_q + 2'd1;
                        end
                    end
                end
                CONV: begin
                    acc_d  = acc_step;
                    step_d = step_q + 2'd1;
                    if (step_q == 2'(NDIG - 1)) begin
                        state_d = DONE;
                        step_d  = 2'd0;
                        value_d = acc_step;
                        valid_d = 1'b1;
                    end
                end
                DONE: begin
                    if (enter) begin
                        state_d = CONV;
                        step_d  = 2'd0;
                        acc_d   = '0;
                    end else if (digit_strobe) begin
                        if (digit_bad) begin
                            state_d = ERR;
                        end else begin
                            // A fresh entry starts from a single digit.
                            state_d = IDLE;
                            d2_d    = 4'd0;
                            d1_d    = 4'd0;
                            d0_d    = digit_in;
                            cnt_d   = 2'd1;
                        end
                    end
                end
                default: ; // ERR: only clear or reset leaves
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_s_n) begin
            state_q <= IDLE;
            step_q  <= 2'd0;
            cnt_q   <= 2'd0;
            d0_q    <= 4'd0;
            d1_q    <= 4'd0;
            d2_q    <= 4'd0;
            acc_q   <= '0;
            value_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            d0_q    <= d0_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            acc_q   <= acc_d;
            value_q <= value_d;
            valid_q <= valid_d;
        end
    end

    assign value = value_q;
    assign valid = valid_q;
    assign busy  = (state_q == CONV);
    assign err   = (state_q == ERR);

    decoder u_dec_u (.digit(d0_q), .seg(unidades));
    decoder u_dec_d (.digit(d1_q), .seg(decenas));
    decoder u_dec_c (.digit(d2_q), .seg(centenas));

endmodule

// File: tb/tb_bcd_entry_reader.sv
module tb_bcd_entry_reader;

    localparam int WIDTH = 10;

    logic             clk = 1'b0;
    logic             rst_s_n;
    logic [3:0]       digit_in;
    logic             digit_strobe;
    logic             enter;
    logic             clear;
    logic [WIDTH-1:0] value;
    logic             valid;
    logic             busy;
    logic             err;
    logic [0:6]       unidades, decenas, centenas;

    int errs = 0;
    int checks = 0;
    logic [0:6] seg_tab [10];

    bcd_entry_reader #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_s_n(rst_s_n), .digit_in(digit_in),
        .digit_strobe(digit_strobe), .enter(enter), .clear(clear),
        .value(value), .valid(valid), .busy(busy), .err(err),
        .unidades(unidades), .decenas(decenas), .centenas(centenas)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int d);
        digit_in     = 4'(d);
        digit_strobe = 1'b1;
        tick();
        digit_strobe = 1'b0;
    endtask

    task automatic chk_echo(input string tag, input int c, input int d, input int u);
        chk({tag, "_cen"}, int'(centenas), int'(seg_tab[c]));
        chk({tag, "_dec"}, int'(decenas),  int'(seg_tab[d]));
        chk({tag, "_uni"}, int'(unidades), int'(seg_tab[u]));
    endtask

    // Pulse enter, then measure enter->valid latency and busy width.
    task automatic conv(input string tag, input int exp_val);
        int lat;
        int bcyc;
        enter = 1'b1;
        tick();
        enter = 1'b0;
        lat  = 99;
        bcyc = busy ? 1 : 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (valid) begin
                lat = i;
                break;
            end
            if (busy) bcyc++;
        end
        chk({tag, "_lat"}, lat, 3);
        chk({tag, "_busy_cycles"}, bcyc, 3);
        chk({tag, "_value"}, int'(value), exp_val);
        chk({tag, "_busy_at_valid"}, int'(busy), 0);
        tick();
        chk({tag, "_valid_width"}, int'(valid), 0);
    endtask

    // Count valid pulses over a window where none should appear.
    task automatic watch_no_valid(input string tag);
        int n;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (valid) n++;
        end
        chk(tag, n, 0);
    endtask

    initial begin
        seg_tab[0] = 7'b1111110; seg_tab[1] = 7'b0110000;
        seg_tab[2] = 7'b1101101; seg_tab[3] = 7'b1111001;
        seg_tab[4] = 7'b0110011; seg_tab[5] = 7'b1011011;
        seg_tab[6] = 7'b1011111; seg_tab[7] = 7'b1110000;
        seg_tab[8] = 7'b1111111; seg_tab[9] = 7'b1111011;

        rst_s_n = 1'b0; digit_in = 4'd0; digit_strobe = 1'b0;
        enter = 1'b0; clear = 1'b0;
        tick(); tick();
        rst_s_n = 1'b1;
        chk("rst_value", int'(value), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_busy",  int'(busy), 0);
        chk("rst_err",   int'(err), 0);
        chk_echo("rst", 0, 0, 0);

        // 4,7,2 -> 472
        strobe(4);
        chk("strobe_visible", int'(unidades), int'(seg_tab[4]));
        strobe(7); strobe(2);
        chk_echo("e472", 4, 7, 2);
        conv("c472", 472);

        // Four digits drop the oldest; reconvert in DONE.
        strobe(1); strobe(2); strobe(3); strobe(9);
        chk_echo("e239", 2, 3, 9);
        conv("c239", 239);
        conv("c239_again", 239);

        // Single digit.
        strobe(5);
        chk_echo("e5", 0, 0, 5);
        conv("c5", 5);

        // Invalid digit locks in ERR until clear.
        strobe(3);
        strobe(12);
        chk("err_set", int'(err), 1);
        chk("err_digits_kept", int'(unidades), int'(seg_tab[3]));
        strobe(4);
        enter = 1'b1; tick(); enter = 1'b0;
        watch_no_valid("err_no_valid");
        chk("err_value_kept", int'(value), 5);
        chk("err_still", int'(err), 1);
        chk("err_echo_unchanged", int'(unidades), int'(seg_tab[3]));
        clear = 1'b1; tick(); clear = 1'b0;
        chk("clr_err", int'(err), 0);
        chk("clr_value", int'(value), 0);
        chk_echo("clr", 0, 0, 0);

        // Enter with no digits.
        conv("c_empty", 0);

        // 999, then a new digit restarts entry without touching value.
        strobe(9); strobe(9); strobe(9);
        conv("c999", 999);
        strobe(6);
        chk_echo("e6", 0, 0, 6);
        chk("e6_value_held", int'(value), 999);

        // Clear two cycles into a conversion.
        strobe(9); strobe(9); strobe(9);
        conv("c999b", 999);
        enter = 1'b1; tick(); enter = 1'b0;
        tick();
        clear = 1'b1; tick(); clear = 1'b0;
        chk("midclr_busy", int'(busy), 0);
        watch_no_valid("midclr_no_valid");
        chk("midclr_value", int'(value), 0);

        // Reset two cycles into a conversion.
        strobe(9); strobe(9); strobe(9);
        conv("c999c", 999);
        enter = 1'b1; tick(); enter = 1'b0;
        tick();
        rst_s_n = 1'b0; tick(); rst_s_n = 1'b1;
        chk("midrst_busy", int'(busy), 0);
        watch_no_valid("midrst_no_valid");
        chk("midrst_value", int'(value), 0);
        chk_echo("midrst", 0, 0, 0);

        // enter beats a simultaneous strobe.
        strobe(8);
        digit_in = 4'd5; digit_strobe = 1'b1; enter = 1'b1;
        tick();
        digit_strobe = 1'b0; enter = 1'b0;
        chk("race_busy", int'(busy), 1);
        chk("race_digit_dropped", int'(unidades), int'(seg_tab[8]));
        begin
            int got;
            got = 0;
            for (int i = 0; i < 8 && !got; i++) begin
                tick();
                if (valid) got = 1;
            end
            chk("race_valid", got, 1);
            chk("race_value", int'(value), 8);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/bcd_entry_reader.md
# bcd_entry_reader

- Reads decimal digits one at a time from switches plus a strobe, holding the last three.
- On request, converts the three BCD digits to binary with a sequential multiply-by-ten accumulator and presents the result with a valid pulse.
- Is the input-side counterpart of the binary-to-7-segment display path: a value keyed in here feeds the adder/counter blocks, while the entered digits are echoed on three 7-segment outputs.

## Interface
- WIDTH, 10, binary result width; must be ≥ 10 (covers 0..999)
- clk  in  1  system clock, all logic on rising edge
- rst_s_n  in  1  reset, synchronous, active-low
- digit_in  in  4  BCD digit to load; valid codes 0..9
- digit_strobe  in  1  one-cycle pulse: load digit_in
- enter  in  1  one-cycle pulse: start conversion
- clear  in  1  one-cycle pulse: discard entry, leave error
- value  out  WIDTH  converted binary result, held until next conversion/clear
- valid  out  1  one-cycle pulse: value just updated
- busy  out  1  high while converting
- err  out  1  high after an invalid digit, until clear/reset
- unidades, decenas, centenas  out  [0:6]  7-segment echo of digit registers d0, d1, d2

## Operation
- Digit registers d2 (hundreds), d1 (tens), d0 (units), plus a digit count cnt (0..3).
- Input priority per cycle: clear > enter > digit_strobe.
- States:
  - IDLE (accept digits)
  - CONV (3 cycles)
  - DONE (result held)
  - ERR
- IDLE:
  - strobe with digit_in ≤ 9: d2←d1, d1←d0, d0←digit_in; cnt saturates at 3. The 4th and later digits drop the oldest (hundreds) digit.
  - strobe with digit_in > 9: go to ERR, err←1; digit registers unchanged.
  - enter: go to CONV. This applies even when cnt = 0; missing digits are 0, so the result is 0.
- CONV:
  - acc←0 on entry.
  - Three accumulate steps in order d2, d1, d0: acc ← (acc<<3) + (acc<<1) + digit.
  - The arithmetic is unsigned at WIDTH bits. With WIDTH ≥ 10, overflow is impossible.
  - strobe and enter are ignored; busy = 1.
- DONE:
  - value holds the result.
  - strobe: clear the digit registers, load the new digit as d0 (cnt = 1), go to IDLE. The invalid-digit rule still applies (go to ERR).
  - enter: reconvert the same digits (go to CONV).
- ERR: strobe and enter are ignored; only clear or reset exits.
- clear from any state, including mid-CONV:
  - digits, cnt and acc ← 0; err ← 0; go to IDLE.
  - value is zeroed; valid is not pulsed.
- Echo outputs are combinational from d0/d1/d2, so they always show the stored digits. They show 0 after reset/clear.

## Timing
- Reset (rst_s_n low at an edge) gives:
  - state IDLE
  - d2 = d1 = d0 = 0, cnt = 0, acc = 0
  - value = 0, valid = 0, busy = 0, err = 0
  - all three echoes show the pattern for "0"
- Reset mid-CONV aborts the conversion: no valid pulse, value = 0.
- enter sampled at edge N: state = CONV, busy = 1 from N.
- Accumulate steps at edges N+1, N+2, N+3.
- Edge N+3: state = DONE, value updated, valid = 1, busy = 0.
- Edge N+4: valid = 0.
- Latency from enter to valid is 3 cycles; valid is exactly one cycle wide.
- A digit strobed at edge M is visible in d0 and on the unidades echo right after M.
- enter and strobe asserted in the same cycle: enter wins and the digit is lost.
- clear in the same cycle as anything else: clear wins.

## Structure
- Shared package holds:
  - the state encoding constants IDLE/CONV/DONE/ERR
  - BCD_MAX = 9
  - the digit count constant NDIG = 3
- Sub-module: instantiate the team's existing `decoder` 7-segment module three times, one per echo output. No other sub-modules.
- The ×10 is done with shifts and adds, with no multiplier inferred. A 2-bit step index drives CONV.

## Test plan
- Reset, then strobe 4, 7, 2, enter: valid pulses exactly 3 cycles after enter; value = 472; echoes show 4, 7, 2; busy is high for exactly 3 cycles.
- Strobe 1, 2, 3, 9, enter: oldest digit dropped, value = 239. Enter again in DONE: second valid, value = 239.
- Strobe 5 only, enter: value = 5. Enter with no digits after clear: value = 0, valid pulses.
- Strobe 3, then digit_in = 12 with strobe: err = 1, state ERR.
  - Later strobe and enter are ignored: no valid, value unchanged.
  - Clear: err = 0, echoes show 0.
- Strobe 9, 9, 9, enter:
  - Assert clear 2 cycles after enter: no valid pulse, value = 0, busy = 0.
  - Repeat with rst_s_n low at the same point: same result.
- After DONE with value = 999, strobe 6: d2 = d1 = 0, d0 = 6, value stays 999 until the next enter.
- enter and strobe in the same cycle from IDLE with digits 0, 0, 8: conversion starts, the digit is dropped, value = 8.
